// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: a small FIFO that decouples SRAM
// return timing from ID stalls, refuses new entries behind a faulting fetch, and empties on redirect.
module fetch_queue #(
  parameter int BUS_W    = 73,
  parameter int DEPTH    = 4,
  parameter int TLBEXC_W = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       fs2ds_valid,
  input  logic [BUS_W-1:0]           fs2ds_bus,
  output logic                       fq_allowin,
  output logic                       fq2ds_valid,
  output logic [BUS_W-1:0]           fq2ds_bus,
  input  logic                       ds_allowin,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [BUS_W-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ex_block_q, ex_block_d;

  logic enq, deq, in_has_ex;

  assign in_has_ex   = |{fs2ds_bus[BUS_W-1 -: TLBEXC_W], fs2ds_bus[0]};
  assign fq_allowin  = resetn & (count_q != FULL) & ~ex_block_q;
  assign fq2ds_valid = (count_q != '0);
  assign fq2ds_bus   = mem[rptr_q];
  assign fq_count    = count_q;

  assign enq = fs2ds_valid & fq_allowin & ~flush;
  assign deq = fq2ds_valid & ds_allowin & ~flush;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ex_block_d = ex_block_q;
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      ex_block_d = 1'b0;
    end else begin
      if (enq) wptr_d = wptr_q + PW'(1);
      if (deq) rptr_d = rptr_q + PW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
      // A faulting fetch is the last useful entry until the redirect arrives.
      if (enq && in_has_ex) ex_block_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ex_block_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ex_block_q <= ex_block_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq) mem[wptr_q] <= fs2ds_bus;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected entries as they are
// accepted, an independent monitor pops and compares each entry handed to ID.
module tb_fetch_queue;

  localparam int BUS_W = 73;
  localparam int DEPTH = 4;

  logic             clk;
  logic             resetn;
  logic             fs2ds_valid;
  logic [BUS_W-1:0] fs2ds_bus;
  logic             fq_allowin;
  logic             fq2ds_valid;
  logic [BUS_W-1:0] fq2ds_bus;
  logic             ds_allowin;
  logic             flush;
  logic [2:0]       fq_count;

  fetch_queue #(.BUS_W(BUS_W), .DEPTH(DEPTH), .TLBEXC_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus), .fq_allowin(fq_allowin),
    .fq2ds_valid(fq2ds_valid), .fq2ds_bus(fq2ds_bus), .ds_allowin(ds_allowin),
    .flush(flush), .fq_count(fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  logic [BUS_W-1:0] sb[$];
  int   m_count = 0;
  logic m_block = 1'b0;

  function automatic logic [BUS_W-1:0] mk(input logic [7:0] t, input logic [31:0] i,
                                          input logic [31:0] p, input logic a);
    return {t, i, p, a};
  endfunction

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive at posedge+1, compare against the model before the edge, advance the model.
  task automatic cyc(input logic v, input logic [BUS_W-1:0] b, input logic da, input logic fl);
    logic m_allow, m_enq, m_deq;
    fs2ds_valid = v;
    fs2ds_bus   = b;
    ds_allowin  = da;
    flush       = fl;
    #3;
    m_allow = resetn && (m_count != DEPTH) && !m_block;
    chk("allowin", BUS_W'(fq_allowin), BUS_W'(m_allow));
    chk("count", BUS_W'(fq_count), BUS_W'(m_count));
    chk("valid", BUS_W'(fq2ds_valid), BUS_W'(m_count != 0));
    m_enq = v && m_allow && !fl;
    m_deq = (m_count != 0) && da && !fl;
    if (fl) begin
      sb.delete();
      m_count = 0;
      m_block = 1'b0;
    end else begin
      if (m_enq) begin
        sb.push_back(b);
        if (|{b[BUS_W-1 -: 8], b[0]}) m_block = 1'b1;
      end
      if (m_enq && !m_deq) m_count++;
      else if (m_deq && !m_enq) m_count--;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (resetn && fq2ds_valid && ds_allowin && !flush) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL mon_unexpected actual=%h required=none", fq2ds_bus);
      end else begin
        logic [BUS_W-1:0] e;
        e = sb.pop_front();
        if (fq2ds_bus !== e) begin
          failures++;
          $display("FAIL mon_entry actual=%h required=%h", fq2ds_bus, e);
        end
        pops++;
      end
    end
  end

  localparam logic [BUS_W-1:0] IDLE = '0;

  initial begin
    int p0;
    resetn = 1'b0; fs2ds_valid = 1'b0; fs2ds_bus = '0; ds_allowin = 1'b0; flush = 1'b0;
    #1;
    chk("rst_valid", BUS_W'(fq2ds_valid), '0);
    chk("rst_allowin", BUS_W'(fq_allowin), '0);
    chk("rst_count", BUS_W'(fq_count), '0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Fill without ID taking anything
    cyc(1'b1, mk(8'h0, 32'h11, 32'h1C000000, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h0, 32'h22, 32'h1C000004, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h0, 32'h33, 32'h1C000008, 1'b0), 1'b0, 1'b0);
    chk("fill3_count", BUS_W'(fq_count), BUS_W'(3));
    chk("fill3_head_pc", BUS_W'(fq2ds_bus[32:1]), BUS_W'(32'h1C000000));
    chk("fill3_allowin", BUS_W'(fq_allowin), BUS_W'(1));
    cyc(1'b1, mk(8'h0, 32'h44, 32'h1C00000C, 1'b0), 1'b0, 1'b0);
    chk("full_allowin", BUS_W'(fq_allowin), '0);
    cyc(1'b1, mk(8'h0, 32'h55, 32'h1C000010, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h0, 32'h55, 32'h1C000010, 1'b0), 1'b0, 1'b0);
    chk("full_hold_count", BUS_W'(fq_count), BUS_W'(4));
    // Dequeue while full: nothing enters in the same cycle
    cyc(1'b1, mk(8'h0, 32'h55, 32'h1C000010, 1'b0), 1'b1, 1'b0);
    chk("deq1_count", BUS_W'(fq_count), BUS_W'(3));
    chk("deq1_head_pc", BUS_W'(fq2ds_bus[32:1]), BUS_W'(32'h1C000004));
    cyc(1'b0, IDLE, 1'b0, 1'b1);
    chk("flush_valid", BUS_W'(fq2ds_valid), '0);

    // Continuous stream across pointer wrap
    p0 = pops;
    for (int i = 0; i < 10; i++)
      cyc(1'b1, mk(8'h0, 32'h100 + 32'(i), 32'h1C000000 + 32'(4 * i), 1'b0), 1'b1, 1'b0);
    cyc(1'b0, IDLE, 1'b1, 1'b0);
    cyc(1'b0, IDLE, 1'b1, 1'b0);
    chk("stream_pops", BUS_W'(pops - p0), BUS_W'(10));
    chk("stream_empty", BUS_W'(fq_count), '0);

    // Flush beats a simultaneous enq and deq
    for (int i = 0; i < 3; i++)
      cyc(1'b1, mk(8'h0, 32'h200 + 32'(i), 32'h1C004000 + 32'(4 * i), 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h0, 32'h2FF, 32'h1C00400C, 1'b0), 1'b1, 1'b1);
    chk("flush_count", BUS_W'(fq_count), '0);
    chk("flush_valid2", BUS_W'(fq2ds_valid), '0);
    cyc(1'b1, mk(8'h0, 32'h300, 32'h1C008000, 1'b0), 1'b1, 1'b0);
    chk("post_flush_count", BUS_W'(fq_count), BUS_W'(1));
    chk("post_flush_pc", BUS_W'(fq2ds_bus[32:1]), BUS_W'(32'h1C008000));
    cyc(1'b0, IDLE, 1'b1, 1'b0);

    // Address-error fetch blocks further entries but still drains
    cyc(1'b1, mk(8'h0, 32'h400, 32'h1C000002, 1'b1), 1'b0, 1'b0);
    chk("adef_allowin", BUS_W'(fq_allowin), '0);
    cyc(1'b1, mk(8'h0, 32'h401, 32'h1C000006, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h0, 32'h402, 32'h1C00000A, 1'b0), 1'b0, 1'b0);
    chk("adef_count", BUS_W'(fq_count), BUS_W'(1));
    cyc(1'b0, IDLE, 1'b1, 1'b0);
    chk("adef_drained", BUS_W'(fq_count), '0);
    chk("adef_still_blocked", BUS_W'(fq_allowin), '0);
    cyc(1'b0, IDLE, 1'b0, 1'b1);
    chk("adef_unblock", BUS_W'(fq_allowin), BUS_W'(1));

    // TLB exception field blocks the same way
    cyc(1'b1, mk(8'h04, 32'h500, 32'h1C000100, 1'b0), 1'b0, 1'b0);
    chk("tlb_allowin", BUS_W'(fq_allowin), '0);
    cyc(1'b0, IDLE, 1'b1, 1'b0);
    cyc(1'b0, IDLE, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle
    cyc(1'b1, mk(8'h0, 32'h600, 32'h1C000200, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h0, 32'h601, 32'h1C000204, 1'b0), 1'b0, 1'b0);
    chk("pre_rst_count", BUS_W'(fq_count), BUS_W'(2));
    fs2ds_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", BUS_W'(fq2ds_valid), '0);
    chk("async_rst_count", BUS_W'(fq_count), '0);
    chk("async_rst_allowin", BUS_W'(fq_allowin), '0);
    sb.delete();
    m_count = 0;
    m_block = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc(1'b0, IDLE, 1'b0, 1'b0);
    chk("sb_leftover", BUS_W'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the IF stage and the ID stage.
- Consumes the IF-to-ID valid/bus pair and presents the same bus format to ID, one entry per cycle.
- Decouples instruction SRAM return timing from ID stalls.
- Drops all buffered instructions on a pipeline redirect (exception, ertn, taken branch).

Parameters:
- BUS_W, 73: width of one entry. Layout is {tlb_exc[TLBEXC_W-1:0], inst[31:0], pc[31:0], adef}.
- DEPTH, 4: number of entries. Must be a power of two, at least 2.
- TLBEXC_W, 8: width of the TLB exception field held in the top bits of an entry.

Ports:
- clk  input  1  Sole clock, rising edge.
- resetn  input  1  Reset. One clock; reset is asynchronous and active-low.
- fs2ds_valid  input  1  IF has a valid entry on fs2ds_bus.
- fs2ds_bus  input  BUS_W  Entry from IF.
- fq_allowin  output  1  Queue accepts an entry this cycle. Drives IF's ds_allowin.
- fq2ds_valid  output  1  Head entry is valid.
- fq2ds_bus  output  BUS_W  Head entry.
- ds_allowin  input  1  ID accepts the head entry this cycle.
- flush  input  1  Redirect (wb_ex | ertn_flush | br_taken). Empties the queue.
- fq_count  output  $clog2(DEPTH)+1  Current occupancy.

Behaviour:
Storage and pointers
- Entry array mem[DEPTH]. Write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy counter count, range 0..DEPTH.
- Block flag ex_block.
- The array contents are not reset. All other state resets.

Reset (resetn=0, asynchronous)
- wptr=0, rptr=0, count=0, ex_block=0.
- Outputs: fq2ds_valid=0, fq_allowin=0 while in reset, fq_count=0.
- fq2ds_bus is don't-care while fq2ds_valid=0.

Handshakes
- fq_allowin = resetn & (count != DEPTH) & ~ex_block.
- fq_allowin depends only on registered state. There is no combinational path from ds_allowin.
- When full, no entry is accepted, even if a dequeue happens in the same cycle.
- enq = fs2ds_valid & fq_allowin & ~flush.
- deq = fq2ds_valid & ds_allowin & ~flush.
- fq2ds_valid = (count != 0).
- fq2ds_bus = mem[rptr]. No bypass: an entry enqueued at edge N is first visible after edge N.

Per clock edge
- On enq: mem[wptr] <= fs2ds_bus and wptr++.
- On deq: rptr++.
- Occupancy update:
  - enq & ~deq: count+1.
  - deq & ~enq: count-1.
  - enq & deq: count unchanged.

Exception blocking
- An entry carries an exception when |{fs2ds_bus[BUS_W-1 -: TLBEXC_W], fs2ds_bus[0]} is set.
- Enqueuing such an entry sets ex_block=1 at that edge.
- While ex_block=1:
  - No further entries are accepted.
  - Already queued entries, including the exception entry, still drain to ID normally.
- ex_block clears only on flush.

Flush
- flush=1 has priority over enq and deq in the same cycle.
- At that edge: count=0, rptr=0, wptr=0, ex_block=0.
- The incoming IF entry is discarded. ID is not considered to have taken the head.
- The queue may accept an entry in the cycle after flush.
- fq2ds_valid is low in the cycle after flush.

Boundaries
- Empty with a simultaneous enq & deq attempt: deq cannot occur (fq2ds_valid=0), so count becomes 1.
- Full: fq_allowin=0.
- Wrap-around: pointers wrap modulo DEPTH with no lost or duplicated entries.
- Reset asserted mid-stream: all entries are lost immediately; outputs go to reset values without waiting for a clock edge.

Test Plan:
- Reset, then push pc 0x1C000000, 0x1C000004, 0x1C000008 (inst 0x11,0x22,0x33), ds_allowin=0 → fq_count=3, fq2ds_bus pc=0x1C000000, fq_allowin=1.
- Continue pushing with ds_allowin=0 to DEPTH=4 → fq_allowin=0 the cycle after the 4th push. Hold fs2ds_valid=1 → count stays 4. Then raise ds_allowin for one cycle → one deq, count=3, head pc=0x1C000004.
- Stream 10 entries with fs2ds_valid=1 and ds_allowin=1 every cycle → ID receives pc 0x1C000000..0x1C000024 in order, each exactly once, across pointer wrap. count never exceeds 1.
- Fill 3 entries, assert flush together with fs2ds_valid=1 and ds_allowin=1 → next cycle count=0 and fq2ds_valid=0. The next push, pc=0x1C008000, appears at the head with count=1.
- Push an entry with adef=1 at pc 0x1C000002 → fq_allowin=0 afterwards. Further IF entries are refused. The adef entry still reaches ID. flush restores fq_allowin=1.
- With count=2, deassert resetn between clock edges → fq2ds_valid=0 and fq_count=0 immediately, before the next edge.
